// File: rtl/led_frame_source.sv
// ----------------------------------------------------------------------------
// led_frame_source
//
// Double-buffered frame source for the LED matrix scanner. A display bank is
// shown pixel by pixel in step with a scan-slot counter, while a shadow bank
// accepts the next frame over a valid/ready handshake. The shadow frame is
// promoted only at the frame boundary, so the display never tears.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   scan_en     slot-advance enable (divider tick)
//   blank       forces data_led low; counter and buffers unaffected
//   wr_valid    new frame offered on wr_data
//   wr_data     frame bits, bit p = pixel p (column p/ROWS, row p%ROWS)
//   wr_ready    shadow bank free to accept a frame
//   slot_idx    current scan slot, 0 (blanking slot) .. NPIX
//   data_led    pixel bit for the current slot
//   frame_sync  high while slot_idx is 0
//   swap_pulse  one-cycle pulse, high in the cycle the new frame starts
// ----------------------------------------------------------------------------
module led_frame_source #(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int NPIX = ROWS * COLS,
  localparam int SW   = $clog2(NPIX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_en,
  input  logic            blank,
  input  logic            wr_valid,
  input  logic [NPIX-1:0] wr_data,
  output logic            wr_ready,
  output logic [SW-1:0]   slot_idx,
  output logic            data_led,
  output logic            frame_sync,
  output logic            swap_pulse
);

  logic [NPIX-1:0] disp;
  logic [NPIX-1:0] shad;
  logic            pending;
  logic [SW-1:0]   slot;
  logic            last_slot;
  logic            accept;
  logic            swap;
  logic            pix_bit;

  assign last_slot = (slot == SW'(NPIX));

  // rst gates ready combinationally so a frame offered on the reset cycle is
  // never taken.
  assign wr_ready = ~pending & ~rst;
  assign accept   = wr_valid & wr_ready;

  // Promotion happens on the enabled cycle that wraps the counter, so the new
  // frame begins with the following slot-0 cycle.
  assign swap = scan_en & last_slot & pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      shad       <= '0;
      pending    <= 1'b0;
      slot       <= '0;
      swap_pulse <= 1'b0;
    end else begin
      if (scan_en) begin
        slot <= last_slot ? '0 : slot + SW'(1);
      end
      // swap needs pending=1 and accept needs pending=0: never both at once.
      if (swap) begin
        disp    <= shad;
        pending <= 1'b0;
      end else if (accept) begin
        shad    <= wr_data;
        pending <= 1'b1;
      end
      swap_pulse <= swap;
    end
  end

  // Slot s (1..NPIX) shows pixel s-1; slot 0 selects nothing and stays dark.
  always_comb begin
    pix_bit = 1'b0;
    for (int p = 0; p < NPIX; p++) begin
      if (slot == SW'(p + 1)) begin
        pix_bit = disp[p];
      end
    end
  end

  assign data_led   = pix_bit & ~blank;
  assign slot_idx   = slot;
  assign frame_sync = (slot == '0);

endmodule

// File: tb/tb_led_frame_source.sv
module tb_led_frame_source;

  localparam int NPIX = 16;
  localparam int SW   = 5;

  logic            clk;
  logic            rst;
  logic            scan_en;
  logic            blank;
  logic            wr_valid;
  logic [NPIX-1:0] wr_data;
  logic            wr_ready;
  logic [SW-1:0]   slot_idx;
  logic            data_led;
  logic            frame_sync;
  logic            swap_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  led_frame_source #(.ROWS(4), .COLS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .blank      (blank),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .slot_idx   (slot_idx),
    .data_led   (data_led),
    .frame_sync (frame_sync),
    .swap_pulse (swap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic blank;
    int   exp_slot;
    logic exp_led;
    logic exp_swap;
  } vec_t;

  vec_t tbl[34];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input int target, output int swaps);
    int n;
    swaps = 0;
    n = 0;
    while (int'(slot_idx) != target && n < 80) begin
      step();
      if (swap_pulse) swaps++;
      n++;
    end
    if (int'(slot_idx) != target) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_slot timeout: got %0d expected %0d", slot_idx, target);
    end
  endtask

  initial begin
    // A5C3 bits 0..15 as the scanner should emit them on slots 1..16
    bit a5c3_bits[16] = '{1,1,0,0, 0,0,1,1, 1,0,1,0, 0,1,0,1};
    int sw;
    int bad;
    int seen;
    int prev;
    int wraps;
    int t_wrap[4];

    // first frame: plain; second frame: blank asserted over slots 5..8
    for (int i = 0; i < 17; i++) begin
      tbl[i].blank    = 1'b0;
      tbl[i].exp_slot = i;
      tbl[i].exp_led  = (i == 0) ? 1'b0 : a5c3_bits[i-1];
      tbl[i].exp_swap = (i == 0);
      tbl[17+i].blank    = (i >= 5 && i <= 8);
      tbl[17+i].exp_slot = i;
      tbl[17+i].exp_led  = (i == 0 || (i >= 5 && i <= 8)) ? 1'b0 : a5c3_bits[i-1];
      tbl[17+i].exp_swap = 1'b0;
    end

    // ---------------- reset with valid offered ----------------
    rst = 1'b1; scan_en = 1'b1; blank = 1'b0;
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst wr_ready", wr_ready, 0);
      check("rst slot_idx", slot_idx, 0);
      check("rst data_led", data_led, 0);
      check("rst frame_sync", frame_sync, 1);
      check("rst swap_pulse", swap_pulse, 0);
    end
    rst = 1'b0; wr_valid = 1'b0;
    step();
    check("post-rst wr_ready", wr_ready, 1);
    check("post-rst slot_idx", slot_idx, 1);

    // ---------------- basic frame A5C3 + blank ----------------
    wait_slot(3, sw);
    wr_valid = 1'b1; wr_data = 16'hA5C3;
    step();
    wr_valid = 1'b0;
    check("basic pending ready", wr_ready, 0);
    wait_slot(16, sw);
    check("basic no early swap", sw, 0);
    for (int i = 0; i < 34; i++) begin
      blank = tbl[i].blank;
      step();
      check($sformatf("tbl[%0d] slot_idx", i), slot_idx, tbl[i].exp_slot);
      check($sformatf("tbl[%0d] data_led", i), data_led, tbl[i].exp_led);
      check($sformatf("tbl[%0d] swap_pulse", i), swap_pulse, tbl[i].exp_swap);
    end
    blank = 1'b0;

    // ---------------- back-pressure ----------------
    wait_slot(2, sw);
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    step();
    wr_data = 16'h0001;
    bad = 0; seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      step();
      if (swap_pulse) seen = 1;
      else if (wr_ready) bad++;
    end
    check("bp swap seen", seen, 1);
    check("bp ready held low", bad, 0);
    check("bp swap slot", slot_idx, 0);
    check("bp ready after swap", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    check("bp 0001 accepted", wr_ready, 0);
    check("bp FFFF slot1", data_led, 1);
    bad = 0;
    for (int s = 2; s <= 16; s++) begin
      step();
      if (data_led !== 1'b1 || int'(slot_idx) != s) bad++;
    end
    check("bp FFFF full frame", bad, 0);
    step();
    check("bp second swap", swap_pulse, 1);
    step();
    check("bp 0001 slot1", data_led, 1);
    step();
    check("bp 0001 slot2", data_led, 0);

    // ---------------- write on the wrap cycle ----------------
    wait_slot(16, sw);
    check("wrap pre swaps", sw, 0);
    wr_valid = 1'b1; wr_data = 16'h00FF;
    step();
    wr_valid = 1'b0;
    check("wrap no swap", swap_pulse, 0);
    check("wrap slot0", slot_idx, 0);
    check("wrap accepted", wr_ready, 0);
    step();
    check("wrap old frame slot1", data_led, 1);
    step();
    check("wrap old frame slot2", data_led, 0);
    wait_slot(16, sw);
    check("wrap old frame no swap", sw, 0);
    step();
    check("wrap late swap", swap_pulse, 1);
    wait_slot(8, sw);
    check("wrap 00FF slot8", data_led, 1);
    step();
    check("wrap 00FF slot9", data_led, 0);

    // ---------------- enable gating 1-in-3 ----------------
    bad = 0; wraps = 0;
    for (int c = 0; c < 120; c++) begin
      scan_en = (c % 3 == 0);
      prev = int'(slot_idx);
      step();
      if ((int'(slot_idx) != prev) != scan_en) bad++;
      if (prev == 16 && slot_idx == 0 && wraps < 4) begin
        t_wrap[wraps] = c;
        wraps++;
      end
    end
    scan_en = 1'b1;
    check("gate advance only on enable", bad, 0);
    check("gate wraps seen", (wraps >= 2) ? 1 : 0, 1);
    if (wraps >= 2) check("gate period", t_wrap[1] - t_wrap[0], 51);

    // ---------------- reset mid-frame with pending ----------------
    wait_slot(2, sw);
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    step();
    wr_valid = 1'b0;
    check("mid pending set", wr_ready, 0);
    wait_slot(9, sw);
    rst = 1'b1;
    step();
    check("mid rst slot", slot_idx, 0);
    check("mid rst led", data_led, 0);
    rst = 1'b0;
    bad = 0; seen = 0;
    for (int c = 0; c < 34; c++) begin
      step();
      if (data_led) bad++;
      if (swap_pulse) seen++;
    end
    check("mid dark frames", bad, 0);
    check("mid no swap", seen, 0);
    check("mid pending dropped", wr_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
